// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port SRAM arbiter.
package mem_arb_pkg;

    localparam int unsigned WE_W     = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SRAM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Requester whose response is being returned in the current cycle.
    function automatic owner_e state_owner(input arb_state_e s);
        case (s)
            RESP_IF: return OWN_IF;
            RESP_DM: return OWN_DM;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive IF arbitration losses; hit forces an IF win.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(STARVE_MAX))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and the MEM stage.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic [WE_W-1:0]   dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic [WE_W-1:0]   sram_w_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    arb_state_e        state_q, state_d;
    owner_e            owner;
    logic              if_elig, dm_elig;
    logic              grant_if, grant_dm, grant_any;
    logic              starve_hit;
    logic              dm_wr_q;
    logic [ADDR_W-1:0] addr_q, grant_addr;
    logic [DATA_W-1:0] if_hold_q, dm_hold_q;

    assign owner = state_owner(state_q);

    // The requester completing this cycle still shows req and is excluded.
    always_comb begin : grant_logic
        state_d    = IDLE;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        grant_addr = addr_q;
        if_elig    = if_req && (owner != OWN_IF);
        dm_elig    = dm_req && (owner != OWN_DM);
        if (if_elig && (!dm_elig || starve_hit)) begin
            grant_if   = 1'b1;
            state_d    = RESP_IF;
            grant_addr = if_addr;
        end else if (dm_elig) begin
            grant_dm   = 1'b1;
            state_d    = RESP_DM;
            grant_addr = dm_addr;
        end
    end

    assign grant_any = grant_if || grant_dm;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (grant_if || !if_req),
        .inc (if_elig && !grant_if),
        .hit (starve_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dm_wr_q   <= 1'b0;
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= grant_addr;
            dm_wr_q <= grant_dm && (dm_we != '0);
            if (state_q == RESP_IF) begin
                if_hold_q <= sram_rdata;
            end
            if ((state_q == RESP_DM) && !dm_wr_q) begin
                dm_hold_q <= sram_rdata;
            end
        end
    end

    // SRAM side is combinational from the grant; reset forces it quiet at once.
    assign sram_w_en  = (rst && grant_dm) ? dm_we : '0;
    assign sram_addr  = rst ? grant_addr : '0;
    assign sram_wdata = (rst && grant_dm) ? dm_wdata : '0;

    assign if_valid = (state_q == RESP_IF);
    assign dm_valid = (state_q == RESP_DM);
    assign if_rdata = if_valid ? sram_rdata : if_hold_q;
    assign dm_rdata = (dm_valid && !dm_wr_q) ? sram_rdata : dm_hold_q;
    assign if_stall = rst && if_req && !if_valid;
    assign dm_stall = rst && dm_req && !dm_valid;

    a_resp_follows_grant : assert property (@(posedge clk) disable iff (!rst)
        (state_q != IDLE) |-> $past(grant_any, SRAM_LAT));

    a_one_valid : assert property (@(posedge clk) disable iff (!rst)
        !(if_valid && dm_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned WORDS      = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid, if_stall;
    logic              dm_req = 1'b0;
    logic [3:0]        dm_we = '0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid, dm_stall;
    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .dm_stall   (dm_stall),
        .sram_w_en  (sram_w_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM with one cycle read latency
    logic [31:0] sram_mem [WORDS];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_w_en[b]) sram_mem[sram_addr[ADDR_W-1:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        sram_rdata <= sram_mem[sram_addr[ADDR_W-1:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory contents, who is answered this cycle, starvation count
    logic [31:0]       m_mem [WORDS];
    int                m_owner = 0;   // 0 none, 1 IF, 2 DM
    int                m_cnt = 0;
    int                if_wait = 0;
    logic [ADDR_W-1:0] m_last_addr = '0;
    logic [31:0]       m_resp = '0, m_if_hold = '0, m_dm_hold = '0;
    bit                m_resp_wr = 1'b0;
    bit                ie, de, gi, gd;
    logic [ADDR_W-1:0] e_addr;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_ctrl", 32'({if_valid, dm_valid, if_stall, dm_stall, sram_w_en}), 32'h0);
            chk("reset_addr", 32'(sram_addr), 32'h0);
            chk("reset_if_rdata", if_rdata, 32'h0);
            chk("reset_dm_rdata", dm_rdata, 32'h0);
            m_owner = 0; m_cnt = 0; if_wait = 0; m_last_addr = '0;
            m_resp = '0; m_if_hold = '0; m_dm_hold = '0; m_resp_wr = 1'b0;
        end else begin
            ie = if_req && (m_owner != 1);
            de = dm_req && (m_owner != 2);
            gi = ie && (!de || (m_cnt == STARVE_MAX));
            gd = de && !gi;
            e_addr = gi ? if_addr : (gd ? dm_addr : m_last_addr);
            chk("if_valid", 32'(if_valid), 32'(m_owner == 1));
            chk("dm_valid", 32'(dm_valid), 32'(m_owner == 2));
            chk("valid_excl", 32'(if_valid && dm_valid), 32'h0);
            chk("if_rdata", if_rdata, (m_owner == 1) ? m_resp : m_if_hold);
            chk("dm_rdata", dm_rdata, (m_owner == 2 && !m_resp_wr) ? m_resp : m_dm_hold);
            chk("if_stall", 32'(if_stall), 32'(if_req && (m_owner != 1)));
            chk("dm_stall", 32'(dm_stall), 32'(dm_req && (m_owner != 2)));
            chk("sram_w_en", 32'(sram_w_en), gd ? 32'(dm_we) : 32'h0);
            chk("sram_addr", 32'(sram_addr), 32'(e_addr));
            if (gd) chk("sram_wdata", sram_wdata, dm_wdata);
            if (if_valid) begin
                chk("if_wait_bound", 32'(if_wait <= STARVE_MAX + 1), 32'h1);
                if_wait = 0;
            end else if (if_req) begin
                if_wait++;
            end else begin
                if_wait = 0;
            end
            if (m_owner == 1) m_if_hold = m_resp;
            if (m_owner == 2 && !m_resp_wr) m_dm_hold = m_resp;
            if (gi) begin
                m_resp = m_mem[if_addr[ADDR_W-1:2]];
                m_resp_wr = 1'b0;
                m_owner = 1;
            end else if (gd) begin
                m_resp = m_mem[dm_addr[ADDR_W-1:2]];
                m_resp_wr = (dm_we != 4'h0);
                for (int b = 0; b < 4; b++) begin
                    if (dm_we[b]) m_mem[dm_addr[ADDR_W-1:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                end
                m_owner = 2;
            end else begin
                m_owner = 0;
            end
            m_last_addr = e_addr;
            if (gi || !if_req) m_cnt = 0;
            else if (ie && m_cnt < STARVE_MAX) m_cnt++;
        end
    end

    // Requester tasks start and end at posedge+1
    task automatic if_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output int lat);
        bit got;
        got = 1'b0; d = '0; lat = -1;
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_valid) begin got = 1'b1; d = if_rdata; lat = i; end
        end
        if (!got) chk("if_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic [3:0] we, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd, output logic [31:0] d, output int lat);
        bit got;
        got = 1'b0; d = '0; lat = -1;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dm_valid) begin got = 1'b1; d = dm_rdata; lat = i; end
        end
        if (!got) chk("dm_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    int          lat, t0, t1;
    bit          sif, sdm;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = $urandom;
            m_mem[i] = sram_mem[i];
        end
        for (int i = 0; i < 3; i++) begin
            sram_mem[i] = 32'hA000_0000 + 32'(4 * i);
            m_mem[i] = sram_mem[i];
        end
        sram_mem[16'h9004 >> 2] = 32'h1122_3344;
        m_mem[16'h9004 >> 2] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // IF alone: three reads, one response per two cycles due to owner exclusion
        if_read(16'h0000, d, lat); chk("t1_if0_data", d, 32'hA000_0000); chk("t1_if0_lat", 32'(lat), 32'd1);
        t0 = $time;
        if_read(16'h0004, d, lat); chk("t1_if1_data", d, 32'hA000_0004);
        t1 = $time;
        chk("t1_spacing", 32'(t1 - t0), 32'd20);
        if_read(16'h0008, d, lat); chk("t1_if2_data", d, 32'hA000_0008);

        // DM full write then read back
        dm_access(4'hF, 16'h9000, 32'hDEAD_BEEF, d, lat); chk("t2_wr_lat", 32'(lat), 32'd1);
        dm_access(4'h0, 16'h9000, 32'h0, d, lat);
        chk("t2_rd_data", d, 32'hDEAD_BEEF); chk("t2_rd_lat", 32'(lat), 32'd1);

        // Byte-lane write merges into existing word
        dm_access(4'b0010, 16'h9004, 32'h0000_AB00, d, lat);
        chk("t5_wr_keeps_rdata", d, 32'hDEAD_BEEF);
        dm_access(4'h0, 16'h9004, 32'h0, d, lat);
        chk("t5_rd_data", d, 32'h1122_AB44);

        // Both requesting continuously: DM, IF, DM, IF ...
        if_req = 1'b1; if_addr = 16'h0004;
        dm_req = 1'b1; dm_we = 4'h0; dm_addr = 16'h9000;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t3_dm_valid", 32'(dm_valid), 32'(k % 2 == 1));
            chk("t3_if_valid", 32'(if_valid), 32'(k > 0 && k % 2 == 0));
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // DM streaming, IF arrives while DM owns the response: IF wins next arbitration
        dm_req = 1'b1; dm_addr = 16'h0000;
        @(posedge clk); #1;
        if_read(16'h0008, d, lat);
        chk("t4_if_lat", 32'(lat), 32'd1);
        chk("t4_if_data", d, 32'hA000_0008);
        dm_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset asserted during a write grant drops the access
        dm_req = 1'b1; dm_we = 4'hF; dm_addr = 16'h9000; dm_wdata = 32'h5555_5555;
        #2;
        chk("t6_wen_before", 32'(sram_w_en), 32'hF);
        rst = 1'b0;
        #1;
        chk("t6_wen_in_reset", 32'(sram_w_en), 32'h0);
        chk("t6_stall_in_reset", 32'(dm_stall), 32'h0);
        @(negedge clk);
        chk("t6_no_valid", 32'(dm_valid || if_valid), 32'h0);
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_no_valid_after", 32'(dm_valid), 32'h0);
        @(posedge clk); #1;
        dm_access(4'h0, 16'h9000, 32'h0, d, lat);
        chk("t6_write_dropped", d, 32'hDEAD_BEEF);

        // Random traffic; one mid-run reset
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            sif = if_valid; sdm = dm_valid;
            @(posedge clk); #1;
            if (i == 1001) rst = 1'b1;
            if (!if_req || sif) begin
                if_req = ($urandom_range(0, 9) < 7);
                if_addr = 16'(($urandom_range(0, 1) != 0 ? 32'h9000 : 32'h0) + 32'($urandom_range(0, 15)) * 4);
            end
            if (!dm_req || sdm) begin
                dm_req = ($urandom_range(0, 9) < 7);
                dm_we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                dm_addr = 16'(($urandom_range(0, 1) != 0 ? 32'h9000 : 32'h0) + 32'($urandom_range(0, 15)) * 4);
                dm_wdata = $urandom;
            end
            if (i == 1000) begin
                #2 rst = 1'b0;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
